// File: rtl/id_ex_register_if.sv
// ID/EX stage boundary bundle: decode-side inputs, execute-side outputs, pipeline control.
// Pure wiring, no latency of its own.
// Carries stall/start/flush so the register sees all of its hold/bubble requests on one port.
interface id_ex_register_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    // pipeline control
    logic              start_i;
    logic              stall_i;
    logic              flush_i;

    // decode-stage payload
    logic              RegWrite_i;
    logic              MemtoReg_i;
    logic              MemRead_i;
    logic              MemWrite_i;
    logic              ALUSrc_i;
    logic [1:0]        ALUOp_i;
    logic [DATA_W-1:0] RS1data_i;
    logic [DATA_W-1:0] RS2data_i;
    logic [DATA_W-1:0] Imm_i;
    logic [9:0]        funct_i;
    logic [4:0]        RS1addr_i;
    logic [4:0]        RS2addr_i;
    logic [4:0]        RDaddr_i;

    // execute-stage payload
    logic              RegWrite_o;
    logic              MemtoReg_o;
    logic              MemRead_o;
    logic              MemWrite_o;
    logic              ALUSrc_o;
    logic [1:0]        ALUOp_o;
    logic [DATA_W-1:0] RS1data_o;
    logic [DATA_W-1:0] RS2data_o;
    logic [DATA_W-1:0] Imm_o;
    logic [9:0]        funct_o;
    logic [4:0]        RS1addr_o;
    logic [4:0]        RS2addr_o;
    logic [4:0]        RDaddr_o;
    logic              valid_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    // upstream side: drives decode payload and control, observes the registered slot
    modport master (
        output start_i, stall_i, flush_i,
        output RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, ALUOp_i,
        output RS1data_i, RS2data_i, Imm_i, funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
        input  RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o,
        input  RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o,
        input  valid_o, bubble_cnt_o
    );

    // pipeline register side
    modport slave (
        input  start_i, stall_i, flush_i,
        input  RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, ALUOp_i,
        input  RS1data_i, RS2data_i, Imm_i, funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
        output RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o,
        output RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o,
        output valid_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures decoded instruction, turns flushes into counted bubbles.
// Latency 1 cycle; every output comes straight from a flop.
// Holds all state while start_i=0 or stall_i=1 (hold beats flush, flush is not remembered).
module id_ex_register #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    id_ex_register_if.slave   bus
);

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_read;
        logic              mem_write;
        logic              alu_src;
        logic [1:0]        alu_op;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [9:0]        funct;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [4:0]        rd_addr;
    } slot_t;

    slot_t            slot_d,       slot_q;
    logic             valid_d,      valid_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

    slot_t            slot_in;
    logic             hold;

    assign slot_in = '{
        reg_write:  bus.RegWrite_i,
        mem_to_reg: bus.MemtoReg_i,
        mem_read:   bus.MemRead_i,
        mem_write:  bus.MemWrite_i,
        alu_src:    bus.ALUSrc_i,
        alu_op:     bus.ALUOp_i,
        rs1_data:   bus.RS1data_i,
        rs2_data:   bus.RS2data_i,
        imm:        bus.Imm_i,
        funct:      bus.funct_i,
        rs1_addr:   bus.RS1addr_i,
        rs2_addr:   bus.RS2addr_i,
        rd_addr:    bus.RDaddr_i
    };

    // CPU not running is treated exactly like a memory stall
    assign hold = !bus.start_i || bus.stall_i;

    // next-state selection: hold > flush (bubble) > load
    always_comb begin
        slot_d       = slot_q;
        valid_d      = valid_q;
        bubble_cnt_d = bubble_cnt_q;
        if (hold) begin
            slot_d       = slot_q;
        end else if (bus.flush_i) begin
            // a bubble clears the whole slot so it can never write regfile or memory
            slot_d  = '0;
            valid_d = 1'b0;
            if (bubble_cnt_q != {CNT_W{1'b1}}) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else begin
            slot_d  = slot_in;
            valid_d = 1'b1;
        end
    end

    // state registers; reset leaves an all-zero bubble in the slot
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q       <= '0;
            valid_q      <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            slot_q       <= slot_d;
            valid_q      <= valid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.RegWrite_o   = slot_q.reg_write;
    assign bus.MemtoReg_o   = slot_q.mem_to_reg;
    assign bus.MemRead_o    = slot_q.mem_read;
    assign bus.MemWrite_o   = slot_q.mem_write;
    assign bus.ALUSrc_o     = slot_q.alu_src;
    assign bus.ALUOp_o      = slot_q.alu_op;
    assign bus.RS1data_o    = slot_q.rs1_data;
    assign bus.RS2data_o    = slot_q.rs2_data;
    assign bus.Imm_o        = slot_q.imm;
    assign bus.funct_o      = slot_q.funct;
    assign bus.RS1addr_o    = slot_q.rs1_addr;
    assign bus.RS2addr_o    = slot_q.rs2_addr;
    assign bus.RDaddr_o     = slot_q.rd_addr;
    assign bus.valid_o      = valid_q;
    assign bus.bubble_cnt_o = bubble_cnt_q;

endmodule

// File: doc/id_ex_register.md
# id_ex_register

ID/EX pipeline register of the five-stage pipelined CPU. It captures the decoded control bits from the decode-stage control unit, together with the register-file operands, immediate, function fields and register addresses. It presents them to the execute stage one cycle later. It holds its contents while the data cache reports a memory stall, and converts flushed or hazard cycles into bubbles. A saturating counter tracks how many bubbles it has inserted.

## Interface
Parameters:
- DATA_W, 32, operand/immediate width
- CNT_W, 16, bubble counter width

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  CPU run enable; 0 = hold all state (same as stall)
- stall_i  in  1  data-cache memory stall; 1 = hold all state
- flush_i  in  1  insert bubble this cycle (hazard/flush request)
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i  in  1 each  decode control bits
- ALUOp_i  in  2  decode ALU op class
- RS1data_i, RS2data_i, Imm_i  in  DATA_W each  operands, sign-extended immediate
- funct_i  in  10  {funct7, funct3}
- RS1addr_i, RS2addr_i, RDaddr_i  in  5 each  register addresses
- RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o  out  1 each  registered control
- ALUOp_o  out  2  registered ALU op class
- RS1data_o, RS2data_o, Imm_o  out  DATA_W each  registered operands
- funct_o  out  10  registered function field
- RS1addr_o, RS2addr_o, RDaddr_o  out  5 each  registered addresses
- valid_o  out  1  1 = slot holds a real instruction, 0 = bubble
- bubble_cnt_o  out  CNT_W  number of bubbles inserted, saturating

## Operation
- Reset (rst_i=1, async): every output is 0, including all control bits, data, addresses, valid_o and bubble_cnt_o. The post-reset slot is a bubble.
- Update priority per rising edge, highest first:
  1. hold: start_i=0 or stall_i=1. All registers keep their value. flush_i is ignored and not remembered. bubble_cnt_o does not change.
  2. flush: flush_i=1. All control outputs and valid_o go to 0. Data, function and address outputs go to 0. bubble_cnt_o increments by 1, saturating at 2^CNT_W-1.
  3. load: all outputs take their corresponding inputs and valid_o goes to 1.
- Bubble counting applies only to flush_i. A cycle in which upstream already zeroed the control bits still loads with valid_o=1.
- No combinational path from any input to any output.
- valid_o=0 means all control outputs are 0. A bubble never writes the register file or memory.
- Storage is plain registers with no read/write bypass. Forwarding is done downstream.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N and persist until the next non-hold edge.
- Stall of k cycles: outputs stay constant for exactly k edges. The load or flush on the first edge with stall_i=0 uses the inputs present at that edge.
- stall_i and flush_i together: the stall wins. The flush must be re-asserted by the hazard logic after the stall.
- Reset asserted mid-stall or mid-flush: outputs go to 0 immediately, with no wait for a clock edge. Deassertion takes effect at the first edge with rst_i=0.
- Counter saturation: at 2^CNT_W-1, further flushes leave the counter unchanged, with no wrap to 0.

## Test plan
- Reset: drive rst_i=1 with nonzero inputs, start_i=1 -> all outputs 0 at once, including while the clock is toggling. Release reset with RegWrite_i=1, RDaddr_i=5, RS1data_i=0x12345678 -> after one edge RegWrite_o=1, RDaddr_o=5, RS1data_o=0x12345678, valid_o=1.
- Stall hold: load Imm_i=0xFFFFFFF0, then set stall_i=1 for 3 edges while Imm_i=0x00000004 -> Imm_o stays 0xFFFFFFF0 for 3 edges. It becomes 0x00000004 on the first edge after stall_i drops.
- Flush: load MemWrite_i=1, ALUOp_i=2'b10, then flush_i=1 for 1 edge -> MemWrite_o=0, ALUOp_o=0, valid_o=0, bubble_cnt_o=1. The next load restores valid_o=1.
- Stall+flush: stall_i=1 and flush_i=1 together for 2 edges -> outputs unchanged, bubble_cnt_o unchanged. Then flush_i=1 alone -> bubble inserted, counter +1.
- Start gating: start_i=0 with changing inputs -> no output changes. start_i=1 -> normal loading resumes.
- Saturation: with CNT_W=4, apply 20 consecutive flushes -> bubble_cnt_o stops at 15 and stays there.
